// File: rtl/sd_cmd_tx_if.sv
// sd_cmd_tx_if: command request handshake into the SD CMD transmitter.
// The host side is the master, the transmitter is the slave.
interface sd_cmd_tx_if;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_index,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_index,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: serialises a 48-bit SD command frame on the CMD line,
// generating the CRC7 bit-serially while the header goes out.
module sd_cmd_tx #(
    parameter int IDLE_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_clk_en,
    sd_cmd_tx_if.slave  cmd,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        busy,
    output logic        done,
    output logic [6:0]  crc_out
);

    localparam int GW = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        GW'((IDLE_BITS > 0) ? IDLE_BITS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CRC,
        S_STOP,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    bit_q, bit_d;
    logic [39:0]   shift_q, shift_d;
    logic [6:0]    crc_q, crc_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          done_q, done_d;
    logic [6:0]    crc_out_q, crc_out_d;

    logic          crc_fb;
    logic [6:0]    crc_nxt;
    logic [2:0]    crc_sel;

    // State register; reset wins over any simultaneous request or tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_q     <= '0;
            shift_q   <= '0;
            crc_q     <= '0;
            gap_q     <= '0;
            done_q    <= 1'b0;
            crc_out_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            crc_q     <= crc_d;
            gap_q     <= gap_d;
            done_q    <= done_d;
            crc_out_q <= crc_out_d;
        end
    end

    // One CRC7 step (x^7+x^3+1) for the header bit currently on the line.
    always_comb begin
        crc_fb  = shift_q[39] ^ crc_q[6];
        crc_nxt = {crc_q[5:3], crc_q[2] ^ crc_fb, crc_q[1:0], crc_fb};
        crc_sel = 3'(6'd46 - bit_q);
    end

    // Next-state: frame sequencing advances only on sd_clk_en ticks.
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        crc_d     = crc_q;
        gap_d     = gap_q;
        done_d    = 1'b0;
        crc_out_d = crc_out_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    state_d = S_HDR;
                    shift_d = {2'b01, cmd.cmd_index, cmd.cmd_arg};
                    crc_d   = '0;
                    bit_d   = '0;
                end
            end
            S_HDR: begin
                if (sd_clk_en) begin
                    crc_d   = crc_nxt;
                    shift_d = {shift_q[38:0], 1'b0};
                    bit_d   = bit_q + 6'd1;
                    if (bit_q == 6'd39) state_d = S_CRC;
                end
            end
            S_CRC: begin
                if (sd_clk_en) begin
                    bit_d = bit_q + 6'd1;
                    if (bit_q == 6'd46) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (sd_clk_en) begin
                    done_d    = 1'b1;
                    crc_out_d = crc_q;
                    bit_d     = '0;
                    gap_d     = '0;
                    state_d   = (IDLE_BITS == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (sd_clk_en) begin
                    gap_d = gap_q + 1'b1;
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line drive: released lines always read high.
    always_comb begin
        sd_cmd_oe  = 1'b0;
        sd_cmd_out = 1'b1;
        unique case (state_q)
            S_HDR: begin
                sd_cmd_oe  = 1'b1;
                sd_cmd_out = shift_q[39];
            end
            S_CRC: begin
                sd_cmd_oe  = 1'b1;
                sd_cmd_out = crc_q[crc_sel];
            end
            S_STOP: begin
                sd_cmd_oe  = 1'b1;
                sd_cmd_out = 1'b1;
            end
            default: begin
                sd_cmd_oe  = 1'b0;
                sd_cmd_out = 1'b1;
            end
        endcase
    end

    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign crc_out       = crc_out_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// tb_sd_cmd_tx: directed frames with hand-computed serial images and CRCs.
// A negedge monitor rebuilds each frame from the CMD line.
module tb_sd_cmd_tx;

    logic       clk;
    logic       reset;
    logic       sd_clk_en;
    logic       sd_cmd_out;
    logic       sd_cmd_oe;
    logic       busy;
    logic       done;
    logic [6:0] crc_out;

    sd_cmd_tx_if ifc ();

    sd_cmd_tx #(.IDLE_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .sd_clk_en  (sd_clk_en),
        .cmd        (ifc.slave),
        .sd_cmd_out (sd_cmd_out),
        .sd_cmd_oe  (sd_cmd_oe),
        .busy       (busy),
        .done       (done),
        .crc_out    (crc_out)
    );

    int ncmp = 0;
    int nerr = 0;

    int          tick_mode = 0;
    int          tick_cnt  = 0;
    int          ndone     = 0;
    int          nbits     = 0;
    int          relviol   = 0;
    int          gap_ticks = 0;
    int          first_cyc = 0;
    int          done_cyc  = 0;
    int          bit0_len  = 0;
    int          cyc       = 0;
    logic        oe_prev   = 1'b0;
    logic [47:0] frame     = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-period strobe: off, continuous, or every 4th cycle.
    initial begin
        sd_clk_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick_cnt++;
            if (tick_mode == 1) sd_clk_en = 1'b1;
            else if (tick_mode == 4) sd_clk_en = (tick_cnt % 4 == 0);
            else sd_clk_en = 1'b0;
        end
    end

    // Line monitor: a bit is taken at the tick that ends it.
    initial begin
        forever begin
            @(negedge clk);
            if (sd_cmd_oe && !oe_prev) begin
                nbits     = 0;
                frame     = '0;
                first_cyc = cyc;
                bit0_len  = 0;
            end
            if (sd_cmd_oe && nbits == 0) bit0_len++;
            if (sd_cmd_oe && sd_clk_en) begin
                frame = {frame[46:0], sd_cmd_out};
                nbits++;
            end
            if (!sd_cmd_oe && !sd_cmd_out) relviol++;
            if (busy && !sd_cmd_oe && sd_clk_en) gap_ticks++;
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            oe_prev = sd_cmd_oe;
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [5:0] idx, input logic [31:0] arg);
        int n;
        n = 0;
        while (!ifc.cmd_ready && n < 1000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!ifc.cmd_ready) chk("ready_timeout", 64'd0, 64'd1);
        ifc.cmd_index = idx;
        ifc.cmd_arg   = arg;
        ifc.cmd_valid = 1'b1;
        @(posedge clk);
        #2;
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int n;
        n = 0;
        while (ndone <= prev && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (ndone <= prev) chk("done_timeout", 64'd0, 64'd1);
        repeat (3) @(negedge clk);
    endtask

    localparam logic [47:0] F_CMD0 = 48'h40_0000_0000_95;
    localparam logic [47:0] F_CMD8 = 48'h48_0000_01AA_87;

    initial begin
        int nd;
        int n;
        reset         = 1'b1;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_index = '0;
        ifc.cmd_arg   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(ifc.cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_oe", 64'(sd_cmd_oe), 64'd0);
        chk("rst_out", 64'(sd_cmd_out), 64'd1);
        chk("rst_crc", 64'(crc_out), 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // CMD0 with a strobe every 4 cycles and an ignored CMD17 request
        tick_mode = 4;
        nd = ndone;
        send(6'd0, 32'h0);
        n = 0;
        while (nbits < 10 && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        ifc.cmd_index = 6'd17;
        ifc.cmd_arg   = 32'hFFFF_FFFF;
        ifc.cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        ifc.cmd_valid = 1'b0;
        wait_done(nd);
        chk("cmd0_frame", 64'(frame), 64'(F_CMD0));
        chk("cmd0_crc", 64'(crc_out), 64'h4A);
        chk("cmd0_nbits", 64'(nbits), 64'd48);
        repeat (40) @(negedge clk);
        chk("cmd0_ndone", 64'(ndone - nd), 64'd1);
        chk("cmd0_idle", 64'(ifc.cmd_ready), 64'd1);

        // CMD8 with a continuous strobe
        tick_mode = 1;
        nd = ndone;
        send(6'd8, 32'h0000_01AA);
        wait_done(nd);
        chk("cmd8_frame", 64'(frame), 64'(F_CMD8));
        chk("cmd8_crc", 64'(crc_out), 64'h43);
        chk("cmd8_lat", 64'(done_cyc - first_cyc), 64'd48);
        chk("cmd8_bit0", 64'(bit0_len), 64'd1);

        // Back-to-back requests with cmd_valid held
        n = 0;
        while (!ifc.cmd_ready && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        nd = ndone;
        gap_ticks = 0;
        ifc.cmd_index = 6'd0;
        ifc.cmd_arg   = 32'h0;
        ifc.cmd_valid = 1'b1;
        n = 0;
        while (ndone <= nd && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_done", 64'(ndone - nd), 64'd1);
        n = 0;
        while (!sd_cmd_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_second_oe", 64'(sd_cmd_oe), 64'd1);
        chk("b2b_gap", 64'(gap_ticks), 64'd8);
        @(posedge clk);
        #2;
        ifc.cmd_valid = 1'b0;
        wait_done(nd + 1);
        chk("b2b_frame", 64'(frame), 64'(F_CMD0));
        chk("b2b_ndone", 64'(ndone - nd), 64'd2);

        // Reset at bit 20 of CMD8
        send(6'd8, 32'h0000_01AA);
        n = 0;
        while (nbits < 20 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached", 64'(nbits >= 20), 64'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        nd = ndone;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_oe", 64'(sd_cmd_oe), 64'd0);
        chk("abort_out", 64'(sd_cmd_out), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_crc", 64'(crc_out), 64'd0);
        repeat (60) @(negedge clk);
        chk("abort_nodone", 64'(ndone - nd), 64'd0);

        // CMD0 accepted on the same cycle as a strobe
        tick_mode = 4;
        n = 0;
        @(posedge clk);
        #2;
        while (!sd_clk_en && n < 16) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("align_tick", 64'(sd_clk_en), 64'd1);
        nd = ndone;
        ifc.cmd_index = 6'd0;
        ifc.cmd_arg   = 32'h0;
        ifc.cmd_valid = 1'b1;
        @(posedge clk);
        #2;
        ifc.cmd_valid = 1'b0;
        wait_done(nd);
        chk("coin_frame", 64'(frame), 64'(F_CMD0));
        chk("coin_crc", 64'(crc_out), 64'h4A);
        chk("coin_bit0", 64'(bit0_len), 64'd4);
        chk("coin_nbits", 64'(nbits), 64'd48);

        chk("released_high", 64'(relviol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
